smu_seq_unit: RTL and testbench

Multi-stage sequence monitor: a parametrised successor to the single-comparator SMU. Each FSM stage has its own segment select, mask, compare value and compare operator. Each stage also has a programmable miss window, so a pattern sequence may contain gaps instead of being strictly consecutive. Sits in the observability fabric between the observable-signal tap and the trigger/remediation logic, configured from the cfg bitstream registers.

---
 rtl/smu_seq_unit_if.sv | 40 ++++
 rtl/smu_seq_unit.sv | 134 +++++++++++++
 tb/tb_smu_seq_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/smu_seq_unit_if.sv
// Port bundle for smu_seq_unit: observable tap, cfg registers and trigger outputs.
// The master side (cfg/tap) drives inputs; the slave side is the sequence monitor.
interface smu_seq_unit_if #(
   parameter int K      = 64,
   parameter int SEG    = 32,
   parameter int STAGES = 4,
   parameter int WIN_W  = 4,
   parameter int HIT_W  = 8
);
   localparam int NSEG = (K + SEG - 1) / SEG;
   localparam int BSEG = (NSEG == 1) ? 1 : $clog2(NSEG);
   localparam int BST  = $clog2(STAGES);

   logic [K-1:0]            i;
   logic                    SmuEn;
   logic                    RegSmuEn;
   logic [STAGES*BSEG-1:0]  RegInpSel;
   logic [STAGES*SEG-1:0]   RegMask;
   logic [STAGES*SEG-1:0]   RegCmp;
   logic [STAGES*2-1:0]     RegCmpSelect;
   logic [STAGES*WIN_W-1:0] RegWin;
   logic [BST-1:0]          RegLastStage;
   logic                    TrigClr;
   logic [BST-1:0]          SmuState;
   logic                    trigger;
   logic                    TrigSticky;
   logic [HIT_W-1:0]        HitCnt;

   modport master (
      output i, SmuEn, RegSmuEn, RegInpSel, RegMask, RegCmp, RegCmpSelect,
             RegWin, RegLastStage, TrigClr,
      input  SmuState, trigger, TrigSticky, HitCnt
   );

   modport slave (
      input  i, SmuEn, RegSmuEn, RegInpSel, RegMask, RegCmp, RegCmpSelect,
             RegWin, RegLastStage, TrigClr,
      output SmuState, trigger, TrigSticky, HitCnt
   );
endinterface

// File: rtl/smu_seq_unit.sv
// Multi-stage sequence monitor with per-stage segment/mask/compare/operator and miss window.
// Optional saturating trigger counter enabled by defining SMU_SEQ_HITCNT_EN.
module smu_seq_unit #(
   parameter int K      = 64,
   parameter int SEG    = 32,
   parameter int STAGES = 4,
   parameter int WIN_W  = 4,
   parameter int HIT_W  = 8
) (
   input logic           clk,
   input logic           rst,
   smu_seq_unit_if.slave bus
);
   localparam int NSEG = (K + SEG - 1) / SEG;
   localparam int BSEG = (NSEG == 1) ? 1 : $clog2(NSEG);
   localparam int BST  = $clog2(STAGES);

   typedef enum logic [1:0] {
      STEP_HOLD,
      STEP_ADVANCE,
      STEP_RESTART,
      STEP_WAIT
   } step_e;

   step_e                step;
   logic                 en;
   logic                 hit;
   logic                 trig;
   logic                 sticky;
   logic [BST-1:0]       state, state_nxt, last;
   logic [WIN_W-1:0]     win_cnt, win_nxt, win_lim;
   logic [NSEG*SEG-1:0]  i_ext;
   logic [BSEG-1:0]      sel;
   logic [SEG-1:0]       seg, mask, cmp;
   logic [1:0]           op;

   function automatic logic cmp_hit(input logic [1:0] o, input logic [SEG-1:0] p,
                                    input logic [SEG-1:0] c);
      case (o)
         2'b01:   return p < c;
         2'b10:   return p > c;
         2'b11:   return p == c;
         default: return 1'b1;
      endcase
   endfunction

   assign en   = bus.SmuEn & bus.RegSmuEn;
   assign last = (int'(bus.RegLastStage) > STAGES - 1) ? BST'(STAGES - 1) : bus.RegLastStage;

   // Per-stage config mux and segment pick; out-of-range selects read as zero
   always_comb begin
      i_ext        = '0;
      i_ext[K-1:0] = bus.i;
      sel          = '0;
      mask         = '0;
      cmp          = '0;
      op           = '0;
      win_lim      = '0;
      for (int s = 0; s < STAGES; s++) begin
         if (int'(state) == s) begin
            sel     = bus.RegInpSel[s*BSEG +: BSEG];
            mask    = bus.RegMask[s*SEG +: SEG];
            cmp     = bus.RegCmp[s*SEG +: SEG];
            op      = bus.RegCmpSelect[s*2 +: 2];
            win_lim = bus.RegWin[s*WIN_W +: WIN_W];
         end
      end
      seg = '0;
      for (int n = 0; n < NSEG; n++) begin
         if (int'(sel) == n) seg = i_ext[n*SEG +: SEG];
      end
   end

   assign hit  = cmp_hit(op, seg & mask, cmp);
   assign trig = en & hit & (state == last) & ~rst;

   always_comb begin
      step      = STEP_HOLD;
      state_nxt = state;
      win_nxt   = win_cnt;
      if (en) begin
         if (state > last)            step = STEP_RESTART;
         else if (hit)                step = (state == last) ? STEP_RESTART : STEP_ADVANCE;
         else if (state == '0)        step = STEP_HOLD;
         else if (win_cnt == win_lim) step = STEP_RESTART;
         else                         step = STEP_WAIT;
      end
      case (step)
         STEP_ADVANCE: begin
            state_nxt = state + 1'b1;
            win_nxt   = '0;
         end
         STEP_RESTART: begin
            state_nxt = '0;
            win_nxt   = '0;
         end
         STEP_WAIT:    win_nxt = win_cnt + 1'b1;
         default:      ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= '0;
         win_cnt <= '0;
         sticky  <= 1'b0;
      end else begin
         state   <= state_nxt;
         win_cnt <= win_nxt;
         if (trig)                    sticky <= 1'b1;
         else if (en && bus.TrigClr)  sticky <= 1'b0;
      end
   end

`ifdef SMU_SEQ_HITCNT_EN
   logic [HIT_W-1:0] hit_cnt;

   // A clear coinciding with a trigger leaves that trigger counted
   always_ff @(posedge clk) begin
      if (rst)                          hit_cnt <= '0;
      else if (trig && bus.TrigClr)     hit_cnt <= HIT_W'(1);
      else if (en && bus.TrigClr)       hit_cnt <= '0;
      else if (trig && hit_cnt != '1)   hit_cnt <= hit_cnt + 1'b1;
   end

   assign bus.HitCnt = hit_cnt;
`else
   assign bus.HitCnt = '0;
`endif

   assign bus.SmuState   = state;
   assign bus.trigger    = trig;
   assign bus.TrigSticky = sticky;
endmodule

// File: tb/tb_smu_seq_unit.sv
// Directed bench for smu_seq_unit: K=80 gives three segments so a select of 3 is out of range.
module tb_smu_seq_unit;
   localparam int K      = 80;
   localparam int SEG    = 32;
   localparam int STAGES = 4;
   localparam int WIN_W  = 4;
   localparam int HIT_W  = 2;
   localparam int BSEG   = 2;
`ifdef SMU_SEQ_HITCNT_EN
   localparam bit HC_ON = 1'b1;
`else
   localparam bit HC_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_chk;
   int   n_pass;

   always #5 clk = ~clk;

   smu_seq_unit_if #(.K(K), .SEG(SEG), .STAGES(STAGES), .WIN_W(WIN_W), .HIT_W(HIT_W)) bus ();

   smu_seq_unit #(.K(K), .SEG(SEG), .STAGES(STAGES), .WIN_W(WIN_W), .HIT_W(HIT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [31:0] hc(input int v);
      return HC_ON ? 32'(v) : 32'd0;
   endfunction

   task automatic set_stage(input int s, input logic [BSEG-1:0] sel, input logic [31:0] mask,
                            input logic [31:0] cmp, input logic [1:0] op, input logic [3:0] win);
      bus.RegInpSel[s*BSEG +: BSEG] = sel;
      bus.RegMask[s*SEG +: SEG]     = mask;
      bus.RegCmp[s*SEG +: SEG]      = cmp;
      bus.RegCmpSelect[s*2 +: 2]    = op;
      bus.RegWin[s*WIN_W +: WIN_W]  = win;
   endtask

   task automatic cfg_strict();
      set_stage(0, 2'd0, 32'hFFFF_FFFF, 32'h11, 2'b11, 4'd0);
      set_stage(1, 2'd0, 32'hFFFF_FFFF, 32'h22, 2'b11, 4'd0);
      set_stage(2, 2'd0, 32'hFFFF_FFFF, 32'h33, 2'b11, 4'd0);
      set_stage(3, 2'd0, 32'hFFFF_FFFF, 32'h44, 2'b11, 4'd0);
      bus.RegLastStage = 2'd2;
   endtask

   // Drive one cycle of data, check the combinational trigger, then step past the edge
   task automatic cyc(input logic [K-1:0] d, input logic exp_trig, input string tag);
      @(negedge clk);
      bus.i = d;
      #1;
      chk(tag, 32'(bus.trigger), 32'(exp_trig));
      @(posedge clk);
      #1;
   endtask

   task automatic chk_st(input string tag, input int exp);
      chk(tag, 32'(bus.SmuState), 32'(exp));
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      rst = 1'b1;
      bus.i = '0;
      bus.SmuEn = 1'b1;
      bus.RegSmuEn = 1'b1;
      bus.TrigClr = 1'b0;
      bus.RegInpSel = '0;
      bus.RegMask = '0;
      bus.RegCmp = '0;
      bus.RegCmpSelect = '0;
      bus.RegWin = '0;
      cfg_strict();
      bus.RegLastStage = 2'd0;

      cyc(80'h11, 1'b0, "rst_trig_a");
      cyc(80'h11, 1'b0, "rst_trig_b");
      chk_st("rst_state", 0);
      chk("rst_sticky", 32'(bus.TrigSticky), 32'd0);
      chk("rst_hitcnt", 32'(bus.HitCnt), 32'd0);
      rst = 1'b0;
      bus.RegLastStage = 2'd2;

      // strict consecutive sequence
      cyc(80'h11, 1'b0, "strict_t1"); chk_st("strict_s1", 1);
      cyc(80'h22, 1'b0, "strict_t2"); chk_st("strict_s2", 2);
      chk("strict_sticky0", 32'(bus.TrigSticky), 32'd0);
      cyc(80'h33, 1'b1, "strict_t3"); chk_st("strict_s3", 0);
      chk("strict_sticky1", 32'(bus.TrigSticky), 32'd1);
      chk("strict_hitcnt", 32'(bus.HitCnt), hc(1));
      bus.TrigClr = 1'b1;
      cyc(80'h0, 1'b0, "clr_t");
      bus.TrigClr = 1'b0;
      chk("clr_sticky", 32'(bus.TrigSticky), 32'd0);
      chk("clr_hitcnt", 32'(bus.HitCnt), 32'd0);

      // two-gap tolerance on stage 1
      set_stage(1, 2'd0, 32'hFFFF_FFFF, 32'h22, 2'b11, 4'd2);
      cyc(80'h11, 1'b0, "gap_t1"); chk_st("gap_s1", 1);
      cyc(80'h00, 1'b0, "gap_t2"); chk_st("gap_s2", 1);
      cyc(80'h00, 1'b0, "gap_t3"); chk_st("gap_s3", 1);
      cyc(80'h22, 1'b0, "gap_t4"); chk_st("gap_s4", 2);
      cyc(80'h33, 1'b1, "gap_t5"); chk_st("gap_s5", 0);

      // three gaps times out; stage 0 not matched by the following data
      cyc(80'h11, 1'b0, "tmo_t1"); chk_st("tmo_s1", 1);
      cyc(80'h00, 1'b0, "tmo_t2"); chk_st("tmo_s2", 1);
      cyc(80'h00, 1'b0, "tmo_t3"); chk_st("tmo_s3", 1);
      cyc(80'h00, 1'b0, "tmo_t4"); chk_st("tmo_s4", 0);
      cyc(80'h22, 1'b0, "tmo_t5"); chk_st("tmo_s5", 0);
      cyc(80'h33, 1'b0, "tmo_t6"); chk_st("tmo_s6", 0);

      // shrinking RegLastStage below the current stage aborts the sequence
      cyc(80'h11, 1'b0, "last_t1");
      cyc(80'h22, 1'b0, "last_t2"); chk_st("last_s2", 2);
      bus.RegLastStage = 2'd1;
      cyc(80'h33, 1'b0, "last_t3"); chk_st("last_s3", 0);

      // operators and segment selection, single-stage sequence
      bus.RegLastStage = 2'd0;
      set_stage(0, 2'd1, 32'hFF, 32'h10, 2'b01, 4'd0);
      cyc(80'h0000_0000_CD0F_0000_0000, 1'b1, "op_lt_hit");
      cyc(80'h0000_0000_CD10_0000_0000, 1'b0, "op_lt_miss");
      set_stage(0, 2'd1, 32'hFF, 32'h10, 2'b10, 4'd0);
      cyc(80'h0000_0000_CD11_0000_0000, 1'b1, "op_gt_hit");
      cyc(80'h0000_0000_CD10_0000_0000, 1'b0, "op_gt_miss");
      set_stage(0, 2'd1, 32'h0, 32'h55, 2'b00, 4'd0);
      cyc(80'h0, 1'b1, "op_always");
      set_stage(0, 2'd2, 32'hFFFF_FFFF, 32'h5, 2'b11, 4'd0);
      cyc(80'h0005_0000_0000_0000_0000, 1'b1, "seg_top_hit");
      cyc(80'hFFFF_0000_0000_0000_0000, 1'b0, "seg_top_miss");
      set_stage(0, 2'd3, 32'hFFFF_FFFF, 32'h0, 2'b11, 4'd0);
      cyc({K{1'b1}}, 1'b1, "seg_oor_zero");
      set_stage(0, 2'd3, 32'hFFFF_FFFF, 32'h5, 2'b11, 4'd0);
      cyc({K{1'b1}}, 1'b0, "seg_oor_miss");
      chk_st("op_state", 0);

      // enable gating at stage 1 with matching data
      cfg_strict();
      set_stage(1, 2'd0, 32'hFFFF_FFFF, 32'h22, 2'b11, 4'd1);
      cyc(80'h11, 1'b0, "en_t1"); chk_st("en_s1", 1);
      bus.SmuEn = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc(80'h22, 1'b0, "en_off_t");
         chk_st("en_off_s", 1);
      end
      bus.SmuEn = 1'b1;
      cyc(80'h22, 1'b0, "en_res_t"); chk_st("en_res_s", 2);
      cyc(80'h33, 1'b1, "en_fin_t"); chk_st("en_fin_s", 0);

      // miss counter holds while disabled, then times out on the next miss
      cyc(80'h11, 1'b0, "wh_t1");
      cyc(80'h00, 1'b0, "wh_t2"); chk_st("wh_s2", 1);
      bus.RegSmuEn = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc(80'h00, 1'b0, "wh_off_t");
         chk_st("wh_off_s", 1);
      end
      bus.RegSmuEn = 1'b1;
      cyc(80'h00, 1'b0, "wh_t3"); chk_st("wh_s3", 0);

      // reset in stage 2 with one miss counted
      set_stage(2, 2'd0, 32'hFFFF_FFFF, 32'h33, 2'b11, 4'd1);
      cyc(80'h11, 1'b0, "rm_t1");
      cyc(80'h22, 1'b0, "rm_t2");
      cyc(80'h00, 1'b0, "rm_t3"); chk_st("rm_s3", 2);
      chk("rm_sticky_pre", 32'(bus.TrigSticky), 32'd1);
      rst = 1'b1;
      cyc(80'h33, 1'b0, "rm_trig");
      chk_st("rm_state", 0);
      chk("rm_sticky", 32'(bus.TrigSticky), 32'd0);
      chk("rm_hitcnt", 32'(bus.HitCnt), 32'd0);
      rst = 1'b0;

      // hit counter saturation and clear-with-trigger
      cfg_strict();
      for (int k = 1; k <= 5; k++) begin
         cyc(80'h11, 1'b0, "hc_t1");
         cyc(80'h22, 1'b0, "hc_t2");
         cyc(80'h33, 1'b1, "hc_t3");
         chk("hc_count", 32'(bus.HitCnt), hc(k < 3 ? k : 3));
      end
      cyc(80'h11, 1'b0, "hcc_t1");
      cyc(80'h22, 1'b0, "hcc_t2");
      bus.TrigClr = 1'b1;
      cyc(80'h33, 1'b1, "hcc_t3");
      bus.TrigClr = 1'b0;
      chk("hcc_count", 32'(bus.HitCnt), hc(1));
      chk("hcc_sticky", 32'(bus.TrigSticky), 32'd1);
      bus.TrigClr = 1'b1;
      cyc(80'h00, 1'b0, "hcz_t");
      bus.TrigClr = 1'b0;
      chk("hcz_count", 32'(bus.HitCnt), 32'd0);
      chk("hcz_sticky", 32'(bus.TrigSticky), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
